// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states, Booth select encodings and sizing for booth_seq_multiplier
package mult_pkg;
  localparam int MULT_W = 32;
  localparam int CNT_W = $clog2(MULT_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {NOP, ADD, SUB} sel_e;
  function automatic sel_e booth_sel(input logic q0, input logic q_m1);
    return (q0 == q_m1) ? NOP : (q0 ? SUB : ADD);
  endfunction
endpackage

// File: rtl/CarryLookahead32Bit.sv
// CarryLookahead32Bit: 32-bit adder, 4-bit lookahead groups chained by group carry
//   A, B : addends      Cin : carry in
//   Sum  : A+B+Cin      Cout: carry out of bit 31
module CarryLookahead32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);
  logic [31:0] g, p;
  logic [32:0] c;
  assign g = A & B;
  assign p = A ^ B;
  always_comb begin
    logic gx, px;
    c = '0;
    c[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      gx = 1'b0;
      px = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gx = g[4*k+i] | (p[4*k+i] & gx);
        px = px & p[4*k+i];
        c[4*k+i+1] = gx | (px & c[4*k]);
      end
    end
  end
  assign Sum  = p ^ c[31:0];
  assign Cout = c[32];
endmodule

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth add/subtract step on the shared adder
//   acc, m, q0, q_m1 : accumulator, multiplicand, Booth pair
//   acc_next         : acc + {0 | m | -m}
//   sgn              : true sign of that sum (overflow-corrected), shifted into acc
module booth_step
  import mult_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [31:0] m,
  input  logic        q0,
  input  logic        q_m1,
  output logic [31:0] acc_next,
  output logic        sgn
);
  sel_e        sel;
  logic [31:0] addend;
  logic        cin, ovf, cout_unused;
  assign sel    = booth_sel(q0, q_m1);
  assign addend = (sel == ADD) ? m : (sel == SUB) ? ~m : '0;
  assign cin    = (sel == SUB);
  CarryLookahead32Bit u_cla (
    .A   (acc),
    .B   (addend),
    .Cin (cin),
    .Sum (acc_next),
    .Cout(cout_unused)
  );
  // A wrapped sum flips bit 31; recovering the real sign keeps a = -2^31 exact.
  assign ovf = (acc[31] == addend[31]) && (acc_next[31] != acc[31]);
  assign sgn = acc_next[31] ^ ovf;
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential signed radix-2 Booth multiplier, 32x32 -> 64 in 32 iterations
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled in IDLE only      a, b : signed operands
//   busy       : iterating                          done : one-cycle result pulse
//   product    : signed result, held until next load
//   ovf32      : (BOOTH_OVF32_EN only) product does not fit in 32-bit signed
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_OVF32_EN
  , output logic               ovf32
`endif
);
  if (WIDTH != MULT_W) begin : g_bad_width
    $error("booth_seq_multiplier supports WIDTH=32 only");
  end
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   s;
  logic               sgn;
`ifdef BOOTH_OVF32_EN
  logic               ovf32_q, ovf32_d;
  assign ovf32 = ovf32_q;
`endif
  booth_step u_step (
    .acc     (acc_q),
    .m       (m_q),
    .q0      (q_q[0]),
    .q_m1    (qm1_q),
    .acc_next(s),
    .sgn     (sgn)
  );
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef BOOTH_OVF32_EN
    ovf32_d   = ovf32_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        m_d     = a;
        q_d     = b;
        acc_d   = '0;
        qm1_d   = 1'b0;
        count_d = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d   = {sgn, s[WIDTH-1:1]};
        q_d     = {s[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          product_d = {acc_d, q_d};
`ifdef BOOTH_OVF32_EN
          ovf32_d   = product_d[2*WIDTH-1:WIDTH] != {WIDTH{product_d[WIDTH-1]}};
`endif
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
`ifdef BOOTH_OVF32_EN
      ovf32_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef BOOTH_OVF32_EN
      ovf32_q   <= ovf32_d;
`endif
    end
  end
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule
